hazard_scoreboard: RTL and testbench

Parametrised successor to the decode-stage hazard/forwarding unit. It sits alongside decode and keeps a per-register scoreboard of in-flight writes, so it supports variable-latency producers (ALU, load, multi-cycle MUL/DIV) and a configurable number of forwarding taps. Each cycle it produces the stall, issue and flush controls, plus per-operand forwarding selects for the instruction in decode.

---
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage scoreboard: per-register pending-write tracking drives stall/issue/flush and forwarding selects.
// Zero-cycle combinational controls; the scoreboard updates on the next edge and freezes under hold_i.
module hazard_scoreboard #(
    parameter  int NUM_REGS       = 32,
    parameter  int REG_AW         = 5,
    parameter  int NUM_FWD_STAGES = 3,
    parameter  int MAX_LAT        = 3,
    parameter  int CNT_W          = 32,
    localparam int LAT_W          = $clog2(MAX_LAT + 1),
    localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              hold_i,
    input  logic              flush_in_i,
    input  logic              de_valid_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              reg_write_i,
    input  logic [LAT_W-1:0]  lat_in_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic              issue_o,
    output logic [SEL_W-1:0]  fwd_a_sel_o,
    output logic [SEL_W-1:0]  fwd_b_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic             v_q   [NUM_REGS];
    logic             v_d   [NUM_REGS];
    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];
    logic [SEL_W-1:0] age_q [NUM_REGS];
    logic [SEL_W-1:0] age_d [NUM_REGS];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             stall;
    logic             issue;
    logic             wr_issue;
    logic [LAT_W-1:0] eff_lat;

    always_comb begin
        eff_lat  = (lat_in_i == '0) ? LAT_W'(1) : lat_in_i;
        raw1     = rs1_used_i && (rs1_i != '0) && v_q[rs1_i] && (cnt_q[rs1_i] != '0);
        raw2     = rs2_used_i && (rs2_i != '0) && v_q[rs2_i] && (cnt_q[rs2_i] != '0);
        // A younger write must never land before an older one to the same register.
        waw      = reg_write_i && (rd_i != '0) && v_q[rd_i] && (cnt_q[rd_i] > eff_lat);
        stall    = de_valid_i && !flush_in_i && (raw1 || raw2 || waw);
        issue    = de_valid_i && !stall && !flush_in_i && !hold_i;
        wr_issue = issue && reg_write_i && (rd_i != '0);
    end

    assign stall_o     = stall;
    assign issue_o     = issue;
    assign flush_o     = flush_in_i;
    assign stall_cnt_o = stall_cnt_q;

    assign fwd_a_sel_o = (rs1_used_i && (rs1_i != '0) && v_q[rs1_i] && (cnt_q[rs1_i] == '0))
                         ? age_q[rs1_i] : '0;
    assign fwd_b_sel_o = (rs2_used_i && (rs2_i != '0) && v_q[rs2_i] && (cnt_q[rs2_i] == '0))
                         ? age_q[rs2_i] : '0;

    always_comb begin
        v_d         = v_q;
        cnt_d       = cnt_q;
        age_d       = age_q;
        stall_cnt_d = stall_cnt_q;
        if (!hold_i) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (wr_issue && (rd_i == REG_AW'(r))) begin
                    v_d[r]   = 1'b1;
                    cnt_d[r] = eff_lat - LAT_W'(1);
                    age_d[r] = SEL_W'(1);
                end else if (v_q[r]) begin
                    if (cnt_q[r] != '0) begin
                        cnt_d[r] = cnt_q[r] - LAT_W'(1);
                    end
                    // Past the last tap the value is only in the register file.
                    if (age_q[r] == SEL_W'(NUM_FWD_STAGES)) begin
                        v_d[r] = 1'b0;
                    end else begin
                        age_d[r] = age_q[r] + SEL_W'(1);
                    end
                end
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            v_q         <= '{default: 1'b0};
            cnt_q       <= '{default: '0};
            age_q       <= '{default: '0};
            stall_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            age_q       <= age_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: linear steps with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic        flush_in;
    logic        de_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  lat_in;
    logic        stall;
    logic        flush;
    logic        issue;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [31:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    hazard_scoreboard dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .hold_i      (hold),
        .flush_in_i  (flush_in),
        .de_valid_i  (de_valid),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rs1_used_i  (rs1_used),
        .rs2_used_i  (rs2_used),
        .rd_i        (rd),
        .reg_write_i (reg_write),
        .lat_in_i    (lat_in),
        .stall_o     (stall),
        .flush_o     (flush),
        .issue_o     (issue),
        .fwd_a_sel_o (fwd_a_sel),
        .fwd_b_sel_o (fwd_b_sel),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs for one decode slot; hold/flush are driven separately.
    task automatic drv(input logic de, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2,
                       input logic [4:0] d, input logic w, input logic [1:0] lat);
        de_valid  = de;
        rs1       = s1;
        rs1_used  = u1;
        rs2       = s2;
        rs2_used  = u2;
        rd        = d;
        reg_write = w;
        lat_in    = lat;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        hold     = 1'b0;
        flush_in = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Populate entries, then reset mid-operation.
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd3);
        chk("pre_issue_x4", issue, 1);
        tick();
        drv(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        chk("pre_stall_x4", stall, 1);
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        drv(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 2'd0);
        chk("rst_stall", stall, 0);
        chk("rst_issue", issue, 1);
        chk("rst_fwd_a", fwd_a_sel, 0);
        chk("rst_fwd_b", fwd_b_sel, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush", flush, 0);
        idle();
        tick();

        // ALU producer x5, latency 1: taps 1,2,3 then register file.
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
        chk("alu_issue", issue, 1);
        tick();
        drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        chk("alu_stall", stall, 0);
        chk("alu_fwd_a1", fwd_a_sel, 1);
        tick();
        drv(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 2'd0);
        chk("alu_fwd_b2", fwd_b_sel, 2);
        tick();
        chk("alu_fwd_b3", fwd_b_sel, 3);
        tick();
        chk("alu_fwd_b0", fwd_b_sel, 0);
        chk("alu_stall_cnt", stall_cnt, 0);
        idle();
        tick();

        // Load-use on x7: one bubble, then tap 2.
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2);
        tick();
        drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 2'd0);
        chk("ld_stall", stall, 1);
        chk("ld_issue0", issue, 0);
        chk("ld_fwd_b0", fwd_b_sel, 0);
        tick();
        chk("ld_stall_clear", stall, 0);
        chk("ld_fwd_b2", fwd_b_sel, 2);
        chk("ld_issue1", issue, 1);
        chk("ld_stall_cnt", stall_cnt, 1);
        idle();
        tick();

        // WAW: slow write to x3 then fast overwrite of x3.
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd3);
        tick();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1);
        chk("waw_stall", stall, 1);
        chk("waw_issue0", issue, 0);
        tick();
        chk("waw_release", stall, 0);
        chk("waw_issue1", issue, 1);
        chk("waw_stall_cnt", stall_cnt, 2);
        tick();
        drv(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        chk("waw_fwd_a1", fwd_a_sel, 1);
        chk("waw_nostall", stall, 0);
        idle();
        tick();

        // x0 is never tracked; unused sources never stall.
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd3);
        tick();
        drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        chk("x0_stall", stall, 0);
        chk("x0_fwd_a", fwd_a_sel, 0);
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd3);
        tick();
        drv(1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 2'd0);
        chk("unused_stall", stall, 0);
        chk("unused_issue", issue, 1);
        drv(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 2'd0);
        chk("used_stall", stall, 1);
        idle();
        tick();

        // HOLD freezes x9 (load) and the counter; STALL stays visible.
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2);
        tick();
        hold = 1'b1;
        drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_stall", stall, 1);
            chk("hold_issue", issue, 0);
            tick();
        end
        chk("hold_stall_cnt", stall_cnt, 2);
        hold = 1'b0;
        #1;
        chk("hold_frozen_stall", stall, 1);
        chk("hold_frozen_fwd", fwd_a_sel, 0);

        // FLUSH_IN overrides the stall and blocks the write of x9.
        flush_in = 1'b1;
        drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1);
        chk("flush_out", flush, 1);
        chk("flush_stall", stall, 0);
        chk("flush_issue", issue, 0);
        tick();
        flush_in = 1'b0;
        drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
        chk("flush_fwd_a2", fwd_a_sel, 2);
        chk("flush_nostall", stall, 0);
        chk("flush_stall_cnt", stall_cnt, 2);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
